// File: rtl/uart_frame_loader_pkg.sv
// Purpose: shared byte codes, FSM state encoding and panel geometry for the UART frame loader.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_frame_loader_pkg;

    // Panel geometry, shared with the LED panel driver.
    localparam int COL_W = 4;   // column index width (16 columns)
    localparam int ROW_W = 8;   // rows per column

    // Byte protocol codes.
    localparam logic [7:0] CMD_SYNC     = 8'hF5;
    localparam logic [3:0] CMD_COLWR_HI = 4'h1;    // 8'h1a, a = column
    localparam logic [7:0] CMD_BULK     = 8'h80;
    localparam logic [7:0] CMD_CLR      = 8'h90;
    localparam logic [3:0] NIB_HI       = 4'h6;    // 8'h6n, n = data nibble
    localparam logic [4:0] COLOUR_HI    = 5'b00000; // 8'h00..8'h07

    localparam logic [COL_W-1:0] LAST_COL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_HI,
        ST_COL_LO,
        ST_BULK_HI,
        ST_BULK_LO,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/uart_frame_loader.sv
// Purpose: parses UART bytes into frame-buffer column writes, bulk loads, clears and colour updates.
// Latency: fb_we/rgb update one cycle after the rx_dv of the completing byte; clear spans 16 cycles.
// Backpressure: none; bytes arriving during a clear are dropped and flagged with err.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   i_rx_dv, i_rx_byte  one-cycle strobe with a received byte
//   o_fb_we/addr/data   one-cycle column write to the panel frame buffer (addr/data hold otherwise)
//   o_rgb               current colour {r,g,b}
//   o_busy              a command is in progress
//   o_frame_done        pulse with the column-15 write of a bulk load or clear
//   o_err               pulse on protocol error, dropped byte or timeout
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [2:0] RGB_RESET      = 3'b101
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_rx_dv,
    input  logic [7:0]       i_rx_byte,
    output logic             o_fb_we,
    output logic [COL_W-1:0] o_fb_addr,
    output logic [ROW_W-1:0] o_fb_data,
    output logic [2:0]       o_rgb,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t           r_state;
    logic [COL_W-1:0] r_addr;
    logic [3:0]       r_hi;
    logic [TW-1:0]    r_tcnt;

    logic       w_is_sync;
    logic       w_is_colour;
    logic       w_is_colwr;
    logic       w_is_bulk;
    logic       w_is_clr;
    logic       w_is_nib;
    logic [3:0] w_nib;
    logic       w_in_cmd;
    logic       w_timeout;

    assign w_is_sync   = (i_rx_byte == CMD_SYNC);
    assign w_is_colour = (i_rx_byte[7:3] == COLOUR_HI);
    assign w_is_colwr  = (i_rx_byte[7:4] == CMD_COLWR_HI);
    assign w_is_bulk   = (i_rx_byte == CMD_BULK);
    assign w_is_clr    = (i_rx_byte == CMD_CLR);
    assign w_is_nib    = (i_rx_byte[7:4] == NIB_HI);
    assign w_nib       = i_rx_byte[3:0];

    // Only the nibble-waiting states are exposed to a stalled sender.
    assign w_in_cmd  = (r_state == ST_COL_HI) || (r_state == ST_COL_LO) ||
                       (r_state == ST_BULK_HI) || (r_state == ST_BULK_LO);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout = w_in_cmd && !i_rx_dv && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_hi         <= '0;
            r_tcnt       <= '0;
            o_fb_we      <= 1'b0;
            o_fb_addr    <= '0;
            o_fb_data    <= '0;
            o_rgb        <= RGB_RESET;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_fb_we      <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;

            if (i_rx_dv || !w_in_cmd) r_tcnt <= '0;
            else                      r_tcnt <= r_tcnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_dv) begin
                        if (w_is_colour) begin
                            o_rgb <= i_rx_byte[2:0];
                        end else if (w_is_colwr) begin
                            r_addr  <= w_nib;
                            r_state <= ST_COL_HI;
                            o_busy  <= 1'b1;
                        end else if (w_is_bulk) begin
                            r_addr  <= '0;
                            r_state <= ST_BULK_HI;
                            o_busy  <= 1'b1;
                        end else if (w_is_clr) begin
                            // Column 0 is written right away so the clear
                            // keeps the same one-cycle latency as other writes.
                            o_fb_we   <= 1'b1;
                            o_fb_addr <= '0;
                            o_fb_data <= '0;
                            r_addr    <= COL_W'(1);
                            r_state   <= ST_CLEAR;
                            o_busy    <= 1'b1;
                        end else if (!w_is_sync) begin
                            o_err <= 1'b1;
                        end
                    end
                end

                ST_COL_HI, ST_BULK_HI, ST_COL_LO, ST_BULK_LO: begin
                    if (i_rx_dv) begin
                        if (w_is_nib && (r_state == ST_COL_HI || r_state == ST_BULK_HI)) begin
                            r_hi    <= w_nib;
                            r_state <= (r_state == ST_COL_HI) ? ST_COL_LO : ST_BULK_LO;
                        end else if (w_is_nib) begin
                            o_fb_we   <= 1'b1;
                            o_fb_addr <= r_addr;
                            o_fb_data <= {r_hi, w_nib};
                            if (r_state == ST_BULK_LO && r_addr != LAST_COL) begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= ST_BULK_HI;
                            end else begin
                                o_frame_done <= (r_state == ST_BULK_LO);
                                r_state      <= ST_IDLE;
                                o_busy       <= 1'b0;
                            end
                        end else begin
                            // SYNC resynchronises silently; anything else is an error.
                            o_err   <= !w_is_sync;
                            r_state <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        o_err   <= 1'b1;
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    o_fb_we   <= 1'b1;
                    o_fb_addr <= r_addr;
                    o_fb_data <= '0;
                    o_err     <= i_rx_dv;
                    if (r_addr == LAST_COL) begin
                        o_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                        o_busy       <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Purpose: randomized scoreboard bench for uart_frame_loader against a protocol-level model.
// Latency: expected events carry the cycle they must appear in.
// Backpressure: none; the driver paces bytes with random gaps.
module tb_uart_frame_loader;

    localparam int         T   = 64;
    localparam logic [2:0] RGB = 3'b101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       fb_we;
    logic [3:0] fb_addr;
    logic [7:0] fb_data;
    logic [2:0] rgb;
    logic       busy;
    logic       frame_done;
    logic       err;

    uart_frame_loader #(.TIMEOUT_CYCLES(T), .RGB_RESET(RGB)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_dv     (rx_dv),
        .i_rx_byte   (rx_byte),
        .o_fb_we     (fb_we),
        .o_fb_addr   (fb_addr),
        .o_fb_data   (fb_data),
        .o_rgb       (rgb),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [7:0] d;
        bit         fd;
        bit         bsy;
    } wr_t;
    typedef struct {
        int         cyc;
        logic [2:0] c;
    } col_t;

    wr_t  wq[$];
    int   eq[$];
    col_t cq[$];

    int nchk  = 0;
    int nfail = 0;
    bit rst_chk  = 1'b0;
    bit fin_req  = 1'b0;
    bit fin_done = 1'b0;

    // ---------------- reference model (protocol level) ----------------
    // mode: 0 idle, 1 column expects hi nibble, 2 column expects lo,
    //       3 bulk expects hi, 4 bulk expects lo
    int         m_mode = 0;
    int         m_addr = 0;
    int         m_hi = 0;
    logic [2:0] m_rgb = RGB;
    int         clr_last = -1;  // last cycle in which an incoming byte is dropped by a clear
    bit         pend = 1'b0;    // a speculative timeout error is queued
    int         pend_cyc = 0;

    task automatic push_wr(input int c, input int a, input int d, input bit fd, input bit bsy);
        wr_t w;
        w.cyc = c; w.a = a[3:0]; w.d = d[7:0]; w.fd = fd; w.bsy = bsy;
        wq.push_back(w);
    endtask

    task automatic model_reset();
        if (pend) void'(eq.pop_back());
        pend = 1'b0; m_mode = 0; m_rgb = RGB; clr_last = -1;
    endtask

    task automatic model_byte(input logic [7:0] b, input int k);
        col_t cc;
        if (pend) begin
            if (k >= pend_cyc) m_mode = 0;       // the timeout already happened
            else void'(eq.pop_back());           // byte arrived in time
            pend = 1'b0;
        end
        if (k <= clr_last) begin
            eq.push_back(k + 1);
            return;
        end
        if (m_mode == 0) begin
            if (b[7:3] == 5'd0) begin
                if (b[2:0] != m_rgb) begin
                    cc.cyc = k + 1; cc.c = b[2:0];
                    cq.push_back(cc);
                end
                m_rgb = b[2:0];
            end else if (b[7:4] == 4'h1) begin
                m_addr = int'(b[3:0]); m_mode = 1;
            end else if (b == 8'h80) begin
                m_addr = 0; m_mode = 3;
            end else if (b == 8'h90) begin
                for (int i = 0; i < 16; i++) push_wr(k + 1 + i, i, 0, i == 15, i < 15);
                clr_last = k + 15;
            end else if (b != 8'hF5) begin
                eq.push_back(k + 1);
            end
        end else if (b[7:4] == 4'h6) begin
            if (m_mode == 1 || m_mode == 3) begin
                m_hi = int'(b[3:0]); m_mode = m_mode + 1;
            end else if (m_mode == 2) begin
                push_wr(k + 1, m_addr, m_hi * 16 + int'(b[3:0]), 1'b0, 1'b0);
                m_mode = 0;
            end else begin
                push_wr(k + 1, m_addr, m_hi * 16 + int'(b[3:0]), m_addr == 15, m_addr != 15);
                if (m_addr == 15) m_mode = 0;
                else begin m_addr = m_addr + 1; m_mode = 3; end
            end
        end else begin
            if (b != 8'hF5) eq.push_back(k + 1);
            m_mode = 0;
        end
        if (m_mode != 0) begin
            pend = 1'b1; pend_cyc = k + 1 + T;
            eq.push_back(pend_cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] b, input int gap);
        rx_dv = 1'b1; rx_byte = b;
        model_byte(b, cyc);
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 19);
        b = 8'($urandom_range(0, 255));
        if (r < 2)       return {5'd0, b[2:0]};
        else if (r < 4)  return {4'h1, b[3:0]};
        else if (r == 4) return 8'h80;
        else if (r == 5) return 8'h90;
        else if (r == 14) return 8'hF5;
        else if (r == 15) return b;
        return {4'h6, b[3:0]};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        logic [2:0] prev_rgb;
        wr_t  w;
        col_t c;
        int   e;
        prev_rgb = RGB;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rgb = rgb;
                if (rst_chk) begin
                    chk("rst_fb_we", int'(fb_we), 0);
                    chk("rst_fb_addr", int'(fb_addr), 0);
                    chk("rst_fb_data", int'(fb_data), 0);
                    chk("rst_rgb", int'(rgb), int'(RGB));
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_frame_done", int'(frame_done), 0);
                    chk("rst_err", int'(err), 0);
                end
            end else begin
                if (fb_we) begin
                    if (wq.size() == 0) chk("unexpected_write", int'(fb_addr), -1);
                    else begin
                        w = wq.pop_front();
                        chk("wr_cycle", cyc, w.cyc);
                        chk("wr_addr", int'(fb_addr), int'(w.a));
                        chk("wr_data", int'(fb_data), int'(w.d));
                        chk("wr_frame_done", int'(frame_done), int'(w.fd));
                        chk("wr_busy", int'(busy), int'(w.bsy));
                    end
                end else if (frame_done) begin
                    chk("frame_done_without_write", 1, 0);
                end
                if (err) begin
                    if (eq.size() == 0) chk("unexpected_err", cyc, -1);
                    else begin
                        e = eq.pop_front();
                        chk("err_cycle", cyc, e);
                    end
                end
                if (rgb != prev_rgb) begin
                    if (cq.size() == 0) chk("unexpected_rgb", int'(rgb), int'(prev_rgb));
                    else begin
                        c = cq.pop_front();
                        chk("rgb_cycle", cyc, c.cyc);
                        chk("rgb_value", int'(rgb), int'(c.c));
                    end
                    prev_rgb = rgb;
                end
                if (wq.size() > 0 && wq[0].cyc < cyc) begin
                    w = wq.pop_front();
                    chk("missing_write_at", cyc, w.cyc);
                end
                if (eq.size() > 0 && eq[0] < cyc) begin
                    e = eq.pop_front();
                    chk("missing_err_at", cyc, e);
                end
                if (cq.size() > 0 && cq[0].cyc < cyc) begin
                    c = cq.pop_front();
                    chk("missing_rgb_at", cyc, c.cyc);
                end
            end
            if (fin_req && !fin_done) begin
                chk("leftover_writes", wq.size(), 0);
                chk("leftover_errs", eq.size(), 0);
                chk("leftover_rgb", cq.size(), 0);
                fin_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        repeat (2) @(negedge clk);
        rst_chk = 1'b1;
        @(negedge clk);
        reset = 1'b0; rst_chk = 1'b0;
        repeat (2) @(negedge clk);

        // colour, single column write, bulk load with column k = k
        send(8'h03, 2);
        send(8'h1A, 1); send(8'h6C, 0); send(8'h65, 3);
        send(8'h80, 1);
        for (int k = 0; k < 16; k++) begin
            send(8'h60, $urandom_range(0, 2));
            send(8'h60 | 8'(k), $urandom_range(0, 2));
        end
        repeat (3) @(negedge clk);

        // clear with a byte injected mid-clear (must be dropped)
        send(8'h90, 4);
        send(8'h05, 20);

        // timeout, resync, illegal byte
        send(8'h15, 0); send(8'h62, T + 10);
        send(8'h15, 1); send(8'hF5, 3);
        send(8'h42, 3);

        // randomized traffic, with occasional stalls long enough to time out
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) send(rand_byte(), T + 3);
            else                            send(rand_byte(), $urandom_range(0, 3));
        end
        send(8'hF5, 30);

        // reset while in the bulk low-nibble state, then a stray nibble
        send(8'h80, 1); send(8'h61, 1);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        rst_chk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; rst_chk = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h63, 5);
        send(8'h06, 40);

        fin_req = 1'b1;
        for (int i = 0; i < 100 && !fin_done; i++) @(negedge clk);
        if (!fin_done) begin
            $display("FAIL final_check: monitor did not complete");
            $fatal(1, "final check not reached");
        end
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
